// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared definitions for the multiplexed 7-segment scan controller:
// parameter defaults, FSM state type and the hex-to-segment patterns.
package seg7_pkg;

  localparam int          DEF_NUM_DIGITS   = 4;
  localparam logic [15:0] DEF_REFRESH_DIV  = 16'd2500;
  localparam logic [7:0]  DEF_BLANK_CYCLES = 8'd16;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  // Segment bit 0 = a ... bit 6 = g, active high.
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  function automatic logic [6:0] seg7_lookup(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = SEG_A;
      4'hB: s = SEG_B;
      4'hC: s = SEG_C;
      4'hD: s = SEG_D;
      4'hE: s = SEG_E;
      default: s = SEG_F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Host-side bus of the scan controller: shadow-digit writes, commit
// handshake and leading-zero suppression control.
interface seg7_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int AW = $clog2(NUM_DIGITS);

  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [3:0]    wr_data;
  logic          swap_req;
  logic          swap_ack;
  logic          lzs_en;

  modport master (
    output wr_valid, wr_addr, wr_data, swap_req, lzs_en,
    input  wr_ready, swap_ack
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, swap_req, lzs_en,
    output wr_ready, swap_ack
  );

endinterface

// File: rtl/seg7_scan_ctrl_seg7.sv
// Hex nibble to 7-segment pattern; one instance is shared by all digits.
module seg7
  import seg7_pkg::*;
(
  input  logic [3:0] count,
  output logic [6:0] seg
);

  // Pure lookup, no state.
  always_comb begin
    seg = seg7_lookup(count);
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller. Digits are written into a shadow
// bank and copied to the displayed (active) bank at a frame boundary after
// a swap request. Each digit gets an optional all-off dead time (BLANK)
// followed by REFRESH_DIV cycles of drive. an_n/segments are registered and
// computed from the next state so they move on the same edge as the FSM.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int          NUM_DIGITS   = DEF_NUM_DIGITS,
  parameter logic [15:0] REFRESH_DIV  = DEF_REFRESH_DIV,
  parameter logic [7:0]  BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  seg7_scan_ctrl_if.slave       bus,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic [6:0]            segments,
  output logic                  frame_tick
);

  localparam int            CW       = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CUR_LAST = CW'(NUM_DIGITS - 1);
  localparam logic [15:0]   DRV_LAST = REFRESH_DIV - 16'd1;
  // Only meaningful when BLANK_CYCLES != 0; NO_BLANK guards the other case.
  localparam logic [7:0]    BLK_LAST = BLANK_CYCLES - 8'd1;
  localparam bit            NO_BLANK = (BLANK_CYCLES == 8'd0);

  state_t                     state, state_nxt;
  logic [CW-1:0]              cur, cur_nxt;
  logic [15:0]                dcnt, dcnt_nxt;
  logic [7:0]                 bcnt, bcnt_nxt;
  logic [NUM_DIGITS-1:0][3:0] shadow, active, active_nxt;
  logic                       pending, commit, addr_ok;
  logic [CW-1:0]              hi_nz;
  logic                       lead_blank;
  logic [3:0]                 dec_in;
  logic [6:0]                 dec_seg;
  logic [NUM_DIGITS-1:0]      an_nxt;
  logic [6:0]                 seg_nxt;

  // Scan FSM: dead time, then drive, then advance to the next digit.
  // Reset parks in BLANK; with no dead time it leaves after one cycle.
  always_comb begin
    state_nxt  = state;
    cur_nxt    = cur;
    dcnt_nxt   = dcnt;
    bcnt_nxt   = bcnt;
    frame_tick = 1'b0;
    case (state)
      ST_BLANK: begin
        if (NO_BLANK || bcnt == BLK_LAST) begin
          state_nxt = ST_DRIVE;
          bcnt_nxt  = '0;
        end else begin
          bcnt_nxt = bcnt + 8'd1;
        end
      end
      ST_DRIVE: begin
        if (dcnt == DRV_LAST) begin
          dcnt_nxt   = '0;
          cur_nxt    = (cur == CUR_LAST) ? '0 : cur + CW'(1);
          frame_tick = (cur == CUR_LAST);
          state_nxt  = NO_BLANK ? ST_DRIVE : ST_BLANK;
        end else begin
          dcnt_nxt = dcnt + 16'd1;
        end
      end
      default: state_nxt = ST_BLANK;
    endcase
  end

  // Commit only on a frame boundary that was already pending; a request
  // arriving on the boundary itself waits for the next one.
  assign commit      = frame_tick & pending;
  assign active_nxt  = commit ? shadow : active;
  assign addr_ok     = int'(bus.wr_addr) < NUM_DIGITS;
  assign bus.wr_ready = ~pending;

  // Highest-index nonzero digit of what will be displayed; digit 0 by default.
  always_comb begin
    hi_nz = '0;
    for (int i = 1; i < NUM_DIGITS; i++)
      if (active_nxt[i] != 4'd0) hi_nz = CW'(i);
  end

  assign dec_in     = active_nxt[cur_nxt];
  assign lead_blank = bus.lzs_en & (cur_nxt > hi_nz);

  seg7 u_seg7 (
    .count (dec_in),
    .seg   (dec_seg)
  );

  // Next display outputs, derived from the next state so they register in step.
  always_comb begin
    an_nxt  = '1;
    seg_nxt = '0;
    if (state_nxt == ST_DRIVE) begin
      an_nxt[cur_nxt] = 1'b0;
      if (!lead_blank) seg_nxt = dec_seg;
    end
  end

  // Scan state and registered display outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_BLANK;
      cur      <= '0;
      dcnt     <= '0;
      bcnt     <= '0;
      an_n     <= '1;
      segments <= '0;
    end else begin
      state    <= state_nxt;
      cur      <= cur_nxt;
      dcnt     <= dcnt_nxt;
      bcnt     <= bcnt_nxt;
      an_n     <= an_nxt;
      segments <= seg_nxt;
    end
  end

  // Digit banks and the commit handshake; extra swap requests merge.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow       <= '0;
      active       <= '0;
      pending      <= 1'b0;
      bus.swap_ack <= 1'b0;
    end else begin
      if (bus.wr_valid && bus.wr_ready && addr_ok)
        shadow[bus.wr_addr] <= bus.wr_data;
      active       <= active_nxt;
      pending      <= commit ? 1'b0 : (pending | bus.swap_req);
      bus.swap_ack <= commit;
    end
  end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of multiplexed digits, legal range 2..8.
REQ-002 SHALL have parameter REFRESH_DIV, default 16'd2500: clk cycles each digit is driven, legal range 1..65535.
REQ-003 SHALL have parameter BLANK_CYCLES, default 8'd16: all-anodes-off dead time between digits; 0 means no dead time.
REQ-004 SHALL have port clk, input, 1: clock.
REQ-005 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port wr_valid, input, 1: shadow-digit write request.
REQ-007 SHALL have port wr_ready, output, 1: write accepted when wr_valid && wr_ready.
REQ-008 SHALL have port wr_addr, input, $clog2(NUM_DIGITS): shadow digit index.
REQ-009 SHALL have port wr_data, input, 4: hex nibble for that digit.
REQ-010 SHALL have port swap_req, input, 1: single-cycle strobe requesting shadow-to-active commit.
REQ-011 SHALL have port swap_ack, output, 1: one-cycle pulse when the commit happens.
REQ-012 SHALL have port lzs_en, input, 1: leading-zero suppression enable.
REQ-013 SHALL have port an_n, output, NUM_DIGITS: one-hot-low digit anode enables.
REQ-014 SHALL have port segments, output, 7: active-high segments a..g of the selected digit.
REQ-015 SHALL have port frame_tick, output, 1: one-cycle pulse at the end of each full scan.

Function
REQ-016 SHALL run FSM states BLANK and DRIVE; BLANK lasts BLANK_CYCLES cycles with an_n all ones and segments 0, then DRIVE lasts REFRESH_DIV cycles; BLANK is skipped when BLANK_CYCLES==0.
REQ-017 SHALL hold a digit index cur; in DRIVE, an_n[cur]=0, all other bits 1, and segments = decode(active[cur]).
REQ-018 SHALL increment cur at the end of DRIVE, wrapping NUM_DIGITS-1 -> 0.
REQ-019 SHALL assert frame_tick for exactly one cycle on the last DRIVE cycle of digit NUM_DIGITS-1.
REQ-020 SHALL register an_n and segments, changing them on the same clk edge as the FSM state and cur change, with no glitch cycle between them.
REQ-021 SHALL write wr_data into shadow[wr_addr] on a cycle with wr_valid && wr_ready; wr_addr >= NUM_DIGITS SHALL be accepted and ignored.
REQ-022 SHALL latch swap_req into a pending flag; while pending, wr_ready=0.
REQ-023 SHALL copy all shadow digits to active registers in the cycle frame_tick is high if pending, pulse swap_ack the following cycle, and clear pending.
REQ-024 SHALL, when a write and swap_req occur in the same cycle, accept the write and include it in the commit.
REQ-025 SHALL, when swap_req arrives while already pending, merge it into the single pending commit (one swap_ack).
REQ-026 SHALL, when swap_req coincides with frame_tick, commit at the next frame boundary, not the current one.
REQ-027 SHALL, when lzs_en=1, blank (segments 0, anode still enabled) every digit above the highest-index nonzero active digit; digit 0 SHALL never be suppressed; all-zero shows "0".
REQ-028 SHALL use counter widths of 16 bits (DRIVE) and 8 bits (BLANK), each counting from 0 to its terminal value then clearing.

Reset
REQ-029 SHALL, while reset is high, set state=BLANK, cur=0, counters=0, an_n all ones, segments=0, frame_tick=0, swap_ack=0, pending=0, wr_ready=1, and shadow and active digits all 0.
REQ-030 SHALL, on reset asserted mid-scan or mid-pending, discard any pending commit with no swap_ack.

Structure
REQ-031 SHALL take default parameter values and the 7-bit segment pattern constants from shared package seg7_pkg.
REQ-032 SHALL instantiate exactly one seg7 sub-module (4-bit counter in, 7-bit segments out), shared across all digits via the cur multiplexer.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=2, 24-cycle frame)
REQ-033 SHALL cover reset release: 2 cycles an_n=4'b1111, then an_n=4'b1110 for 4 cycles, then 1111 for 2 cycles, then 1101; frame_tick high on cycle 24.
REQ-034 SHALL cover write+commit: write shadow {3,2,1,0}={1,2,3,4}, pulse swap_req -> wr_ready=0 until frame end, swap_ack next cycle, digit0 shows seg7(4), digit3 shows seg7(1).
REQ-035 SHALL cover simultaneous events: write addr 2 data 9 in the same cycle as swap_req -> write accepted, digit2 shows seg7(9) after commit; second swap_req while pending -> single swap_ack.
REQ-036 SHALL cover LZS: active={0,0,5,0} (d3..d0), lzs_en=1 -> d3 and d2 segments 0, d1 seg7(5), d0 seg7(0); all zero -> only d0 shows seg7(0).
REQ-037 SHALL cover reset mid-pending: swap_req then reset at cycle 10 -> no swap_ack, active digits all 0, scan restarts at BLANK with cur=0.
REQ-038 SHALL cover BLANK_CYCLES=0: an_n steps 1110 -> 1101 on consecutive cycles with no all-ones gap.
